// File: rtl/motion_executor.sv
// Motion executor: accepts one motion command from task_manager, ramps motor
// PWM duty up, holds it for the commanded seconds, ramps it down, then pulses
// done. It drives the H-bridge PWM and direction pins directly.
module motion_executor #(
  parameter  int PWM_PERIOD = 256,
  parameter  int DUTY_MAX   = 200,
  parameter  int RAMP_STEP  = 8,
  parameter  int RAMP_DIV   = 1024,
  localparam int DW         = $clog2(PWM_PERIOD + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          oneHz_enable,
  input  logic          cmd_valid,
  input  logic [1:0]    cmd_op,
  input  logic [3:0]    cmd_secs,
  input  logic          abort,
  output logic          cmd_ready,
  output logic          done,
  output logic          busy,
  output logic [1:0]    state,
  output logic [DW-1:0] duty,
  output logic          pwm_left,
  output logic          pwm_right,
  output logic          dir_left,
  output logic          dir_right
);

  localparam int CW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RAMP_UP   = 2'b01,
    RUN       = 2'b10,
    RAMP_DOWN = 2'b11
  } state_t;

  state_t        st;
  logic          pend;      // command latched, start/finish decided next edge
  logic [1:0]    op_q;
  logic [3:0]    secs_q;
  logic [RW-1:0] ramp_cnt;
  logic [CW-1:0] pwm_cnt;
  logic [DW-1:0] duty_q;
  logic [DW-1:0] duty_up;
  logic [DW-1:0] duty_dn;
  logic          done_q;
  logic          dl_q;
  logic          dr_q;
  logic          ramp_tick;
  logic          secs_last;

  assign ramp_tick = (ramp_cnt == RW'(RAMP_DIV - 1));
  assign secs_last = oneHz_enable && (secs_q == 4'd1);

  assign cmd_ready = (st == IDLE) && !pend;
  assign busy      = (st != IDLE);
  assign state     = st;
  assign duty      = duty_q;
  assign done      = done_q;
  assign dir_left  = dl_q;
  assign dir_right = dr_q;
  assign pwm_left  = (DW'(pwm_cnt) < duty_q);
  assign pwm_right = (DW'(pwm_cnt) < duty_q);

  // Saturating next-duty values for the ramp phases.
  always_comb begin
    duty_up = duty_q + DW'(RAMP_STEP);
    duty_dn = duty_q - DW'(RAMP_STEP);
    if (int'(duty_q) + RAMP_STEP >= DUTY_MAX) duty_up = DW'(DUTY_MAX);
    if (int'(duty_q) <= RAMP_STEP)            duty_dn = '0;
  end

  // Free-running PWM frame counter, independent of the command state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             pwm_cnt <= '0;
    else if (pwm_cnt == CW'(PWM_PERIOD - 1))  pwm_cnt <= '0;
    else                                      pwm_cnt <= pwm_cnt + CW'(1);
  end

  // Command sequencer: accept, ramp up, hold, ramp down, done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st       <= IDLE;
      pend     <= 1'b0;
      op_q     <= '0;
      secs_q   <= '0;
      ramp_cnt <= '0;
      duty_q   <= '0;
      done_q   <= 1'b0;
      dl_q     <= 1'b0;
      dr_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (st)
        IDLE: begin
          if (pend) begin
            pend <= 1'b0;
            if (op_q == 2'b00 || secs_q == 4'd0) begin
              done_q <= 1'b1;
            end else begin
              st       <= RAMP_UP;
              ramp_cnt <= '0;
              dl_q     <= (op_q != 2'b10);  // left wheel reverses only on turn left
              dr_q     <= (op_q != 2'b11);  // right wheel reverses only on turn right
            end
          end else if (cmd_valid) begin
            pend   <= 1'b1;
            op_q   <= cmd_op;
            secs_q <= cmd_secs;
          end
        end
        RAMP_UP, RUN: begin
          // abort beats the seconds tick; duty is frozen on the exit edge
          if (abort || secs_last) begin
            st       <= RAMP_DOWN;
            ramp_cnt <= '0;
            if (!abort) secs_q <= 4'd0;
          end else begin
            if (oneHz_enable) secs_q <= secs_q - 4'd1;
            if (st == RAMP_UP) begin
              if (ramp_tick) begin
                ramp_cnt <= '0;
                duty_q   <= duty_up;
                if (duty_up == DW'(DUTY_MAX)) st <= RUN;
              end else begin
                ramp_cnt <= ramp_cnt + RW'(1);
              end
            end
          end
        end
        RAMP_DOWN: begin
          if (duty_q == '0) begin
            st     <= IDLE;
            done_q <= 1'b1;
            dl_q   <= 1'b0;
            dr_q   <= 1'b0;
          end else if (ramp_tick) begin
            ramp_cnt <= '0;
            duty_q   <= duty_dn;
            if (duty_dn == '0) begin
              st     <= IDLE;
              done_q <= 1'b1;
              dl_q   <= 1'b0;
              dr_q   <= 1'b0;
            end
          end else begin
            ramp_cnt <= ramp_cnt + RW'(1);
          end
        end
      endcase
    end
  end

endmodule
